// File: rtl/elevator_if.sv
// Request/status bundle between the request latches and the car-motion controller.
interface elevator_if;
  logic [3:0] request_seq;
  logic [1:0] current_floor;
  logic       opnd;
  logic [3:0] served;
  logic       moving;
  logic       dir_up;

  // Request latches: drive pending requests, observe car status.
  modport master (
    output request_seq,
    input  current_floor, opnd, served, moving, dir_up
  );

  // Controller: consume pending requests, drive car status.
  modport slave (
    input  request_seq,
    output current_floor, opnd, served, moving, dir_up
  );
endinterface

// File: rtl/elevator_ctrl.sv
// Four-floor car-motion controller: moves the car floor by floor toward pending
// requests and holds the door open for a fixed time at each requested floor.
module elevator_ctrl #(
  parameter int unsigned FLOOR_TICKS = 8,
  parameter int unsigned DOOR_TICKS  = 6
) (
  input logic       clk,
  input logic       rst,
  elevator_if.slave bus
);

  localparam int unsigned NFLOORS = 4;
  localparam int unsigned FW      = 2;
  localparam int unsigned TW      = $clog2(FLOOR_TICKS);
  localparam int unsigned DW      = $clog2(DOOR_TICKS + 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t             state;
  logic [FW-1:0]      cur_floor;
  logic               opnd;
  logic [NFLOORS-1:0] served;
  logic               moving;
  logic               dir_up;
  logic [TW-1:0]      trav_cnt;
  logic [DW-1:0]      door_cnt;

  logic               above;
  logic               below;
  logic               here;
  logic               ahead;
  logic [FW-1:0]      nf;

  // Request position relative to the car, and beyond the next floor in travel direction.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    ahead = 1'b0;
    here  = bus.request_seq[cur_floor];
    nf    = dir_up ? cur_floor + FW'(1) : cur_floor - FW'(1);
    for (int i = 0; i < int'(NFLOORS); i++) begin
      if (bus.request_seq[i] && (FW'(i) > cur_floor)) above = 1'b1;
      if (bus.request_seq[i] && (FW'(i) < cur_floor)) below = 1'b1;
      if (bus.request_seq[i] && (dir_up ? (FW'(i) > nf) : (FW'(i) < nf))) ahead = 1'b1;
    end
  end

  // Controller state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_floor <= '0;
      opnd      <= 1'b0;
      served    <= '0;
      moving    <= 1'b0;
      dir_up    <= 1'b1;
      trav_cnt  <= '0;
      door_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (here) begin
            state    <= DOOR;
            opnd     <= 1'b1;
            served   <= NFLOORS'(1) << cur_floor;
            door_cnt <= '0;
          end else if (above && (dir_up || !below)) begin
            state    <= MOVE;
            moving   <= 1'b1;
            dir_up   <= 1'b1;
            trav_cnt <= '0;
          end else if (below) begin
            state    <= MOVE;
            moving   <= 1'b1;
            dir_up   <= 1'b0;
            trav_cnt <= '0;
          end
        end
        MOVE: begin
          if (trav_cnt == TW'(FLOOR_TICKS - 1)) begin
            cur_floor <= nf;
            trav_cnt  <= '0;
            if (bus.request_seq[nf]) begin
              state    <= DOOR;
              moving   <= 1'b0;
              opnd     <= 1'b1;
              served   <= NFLOORS'(1) << nf;
              door_cnt <= '0;
            end else if (!ahead) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            trav_cnt <= trav_cnt + TW'(1);
          end
        end
        DOOR: begin
          if (door_cnt == DW'(DOOR_TICKS - 1)) begin
            state    <= IDLE;
            opnd     <= 1'b0;
            served   <= '0;
            door_cnt <= '0;
          end else begin
            door_cnt <= door_cnt + DW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          opnd   <= 1'b0;
          served <= '0;
          moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.current_floor = cur_floor;
  assign bus.opnd          = opnd;
  assign bus.served        = served;
  assign bus.moving        = moving;
  assign bus.dir_up        = dir_up;

endmodule
